hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5, register-address width.
REQ-002 SHALL have parameter LU_CYC, default 1, load-use stall length in cycles (1..15).
REQ-003 SHALL have parameter FL_CYC, default 1, branch flush length in cycles (1..15).
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high.
REQ-006 SHALL have ports id_rs1, id_rs2  in  RA_W  source registers in ID.
REQ-007 SHALL have ports ex_rd  in  RA_W and ex_mem_read  in  1  destination register and load flag in EX.
REQ-008 SHALL have ports ex_branch_taken  in  1 and dmem_busy  in  1  taken branch in EX; data memory not ready.
REQ-009 SHALL have outputs pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, each  out  1; pc_stall feeds the program counter Stall input.
REQ-010 SHALL have output state_o  out  2  current FSM state (RUN=0, LU=1, FL=2, MW=3).

Function
REQ-011 Load-use hazard (LU_HIT) SHALL be ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
REQ-012 In RUN, all outputs SHALL be 0 unless an event below is present; outputs SHALL be combinational from state, counter and inputs (zero-cycle reaction).
REQ-013 Event priority SHALL be dmem_busy > ex_branch_taken > LU_HIT.
REQ-014 dmem_busy=1 in any state SHALL assert pc_stall, ifid_stall, exmem_stall, deassert both flushes, go to MW, save the prior state and hold the counter.
REQ-015 In MW, leaving on dmem_busy=0 SHALL restore the saved state and counter unchanged.
REQ-016 ex_branch_taken in RUN or LU SHALL assert ifid_flush and idex_flush, deassert stalls, abandon any LU sequence and, if FL_CYC>1, go to FL with counter=FL_CYC-1.
REQ-017 In FL, both flushes SHALL stay asserted; the counter SHALL decrement each cycle; on reaching 0, state SHALL go to RUN on the next edge.
REQ-018 LU_HIT in RUN SHALL assert pc_stall, ifid_stall and idex_flush (bubble) and, if LU_CYC>1, go to LU with counter=LU_CYC-1.
REQ-019 In LU, the same three outputs SHALL be asserted and the counter SHALL decrement; at 0, state SHALL go to RUN; LU_HIT is re-evaluated only in RUN.
REQ-020 ifid_stall and ifid_flush SHALL never both be 1; pc_stall SHALL equal ifid_stall.
REQ-021 The counter SHALL be 4 bits, decrementing without wrap below 0.

Reset
REQ-022 Reset SHALL force state RUN, counter 0, saved state RUN, all outputs 0, regardless of inputs.
REQ-023 Reset asserted mid-LU, FL or MW SHALL abort the sequence; the first post-reset cycle SHALL evaluate as RUN.

Configuration
REQ-024 With HAZARD_PERF_CNT_EN defined, the block SHALL add outputs lu_cnt, fl_cnt, mw_cnt (32 bits each), counting cycles with LU-type stall, flush and MW stall respectively, saturating at 2^32-1 and reset to 0.
REQ-025 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-026 State encoding constants and the RA_W default SHALL live in shared package pipe_pkg.
REQ-027 The LU_HIT compare SHALL be a sub-module hazard_cmp (combinational; rs1, rs2, rd, mem_read -> hit).
REQ-028 FSM state, counter and saved-state registers SHALL reside in hazard_stall_ctrl.

Verification
REQ-029 Reset held with ex_mem_read=1, ex_rd=3, id_rs1=3 -> all outputs 0, state_o=0.
REQ-030 LU_CYC=2, ex_mem_read=1, ex_rd=5, id_rs2=5 for one cycle -> pc_stall=ifid_stall=idex_flush=1 for exactly 2 cycles, then RUN.
REQ-031 ex_rd=0 with ex_mem_read=1, id_rs1=0 -> no stall.
REQ-032 FL_CYC=2, ex_branch_taken and LU_HIT in the same cycle -> flushes for 2 cycles, pc_stall=0 throughout.
REQ-033 In LU with counter=1, dmem_busy high 3 cycles -> exmem_stall=1 for 3 cycles, then LU resumes for 1 cycle, then RUN.
REQ-034 With HAZARD_PERF_CNT_EN, after REQ-030 and REQ-033 -> lu_cnt=2+1, mw_cnt=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: FSM state encoding, register-address width
// default and the stall/flush counter helpers used by the hazard controller.
package pipe_pkg;

  localparam int unsigned RA_W_DEF = 5;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_FL  = 2'd2,
    ST_MW  = 2'd3
  } hz_state_e;

  // Decrement that stops at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard comparator: flags an ID-stage source that matches the
// destination of a load currently in EX (register 0 never hazards).
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic [RA_W-1:0] rd,
  input  logic            mem_read,
  output logic            hit
);

  // Pure combinational compare.
  always_comb begin
    hit = mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard stall/flush controller.
// Priority: data-memory wait > taken branch > load-use hazard.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W   = RA_W_DEF,
  parameter int unsigned LU_CYC = 1,
  parameter int unsigned FL_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  input  logic            dmem_busy,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_stall,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]     lu_cnt,
  output logic [31:0]     fl_cnt,
  output logic [31:0]     mw_cnt,
`endif
  output logic [1:0]      state_o
);

  localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LU_CYC - 1);
  localparam logic [CNT_W-1:0] FL_INIT = CNT_W'(FL_CYC - 1);

  hz_state_e        state_q, state_d;
  hz_state_e        saved_q, saved_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             lu_hit;

  hazard_cmp #(.RA_W(RA_W)) u_cmp (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rd       (ex_rd),
    .mem_read (ex_mem_read),
    .hit      (lu_hit)
  );

  // State, counter and saved-state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and combinational stall/flush outputs.
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;

    if (dmem_busy) begin
      // Freeze everything; the interrupted state is remembered once, on entry.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      exmem_stall = 1'b1;
      state_d     = ST_MW;
      if (state_q != ST_MW) saved_d = state_q;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (FL_CYC > 1) begin
              state_d = ST_FL;
              cnt_d   = FL_INIT;
            end
          end else if (lu_hit) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            if (LU_CYC > 1) begin
              state_d = ST_LU;
              cnt_d   = LU_INIT;
            end
          end
        end
        ST_LU: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (FL_CYC > 1) begin
              state_d = ST_FL;
              cnt_d   = FL_INIT;
            end else begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end
          end else begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            cnt_d      = sat_dec(cnt_q);
            if (cnt_d == '0) state_d = ST_RUN;
          end
        end
        ST_FL: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = sat_dec(cnt_q);
          if (cnt_d == '0) state_d = ST_RUN;
        end
        ST_MW: begin
          // Memory ready: resume the interrupted sequence with its count intact.
          state_d = saved_q;
          saved_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    if (reset) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_stall = 1'b0;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic [31:0] fl_cnt_q, fl_cnt_d;
  logic [31:0] mw_cnt_q, mw_cnt_d;

  // Saturating event counters.
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    mw_cnt_d = mw_cnt_q;
    if (pc_stall && idex_flush && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + 1'b1;
    if (ifid_flush && (fl_cnt_q != '1))              fl_cnt_d = fl_cnt_q + 1'b1;
    if (exmem_stall && (mw_cnt_q != '1))             mw_cnt_d = mw_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
      mw_cnt_q <= mw_cnt_d;
    end
  end

  assign lu_cnt = lu_cnt_q;
  assign fl_cnt = fl_cnt_q;
  assign mw_cnt = mw_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (LU_CYC=2, FL_CYC=2): each step drives
// inputs after a rising edge, queues the expected output vector and checks it
// mid-cycle. Vector = {pc_stall, ifid_stall, ifid_flush, idex_flush,
// exmem_stall, state_o[1:0]}.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, dmem_busy = 1'b0;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt, fl_cnt, mw_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [6:0]  exp_q[$];

  hazard_stall_ctrl #(.RA_W(5), .LU_CYC(2), .FL_CYC(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_stall     (exmem_stall),
`ifdef HAZARD_PERF_CNT_EN
    .lu_cnt          (lu_cnt),
    .fl_cnt          (fl_cnt),
    .mw_cnt          (mw_cnt),
`endif
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic rst, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic br, input logic busy,
                      input logic [6:0] exp);
    logic [6:0] obs, want;
    @(posedge clk);
    #1;
    reset = rst; ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    ex_branch_taken = br; dmem_busy = busy;
    exp_q.push_back(exp);
    @(negedge clk);
    obs = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, state_o};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: scoreboard empty, got %b", tag, obs);
    end else begin
      want = exp_q.pop_front();
      assert (obs === want) else begin
        n_err++;
        $error("FAIL %s: got %b expected %b", tag, obs, want);
      end
    end
  endtask

  // Expected-vector shorthands.
  localparam logic [6:0] Z_RUN  = 7'b00000_00;
  localparam logic [6:0] Z_MW   = 7'b00000_11;
  localparam logic [6:0] LU_RUN = 7'b11010_00;
  localparam logic [6:0] LU_LU  = 7'b11010_01;
  localparam logic [6:0] FL_RUN = 7'b00110_00;
  localparam logic [6:0] FL_LU  = 7'b00110_01;
  localparam logic [6:0] FL_FL  = 7'b00110_10;
  localparam logic [6:0] MW_RUN = 7'b11001_00;
  localparam logic [6:0] MW_LU  = 7'b11001_01;
  localparam logic [6:0] MW_MW  = 7'b11001_11;

  initial begin
    // Reset held with a live load-use pattern on the inputs.
    step("rst_hold0", 1, 1, 5'd3, 5'd3, 5'd0, 0, 0, Z_RUN);
    step("rst_hold1", 1, 1, 5'd3, 5'd3, 5'd0, 0, 0, Z_RUN);
    step("idle",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);

    // Load-use on rs2: two bubble cycles, then RUN.
    step("lu_hit",    0, 1, 5'd5, 5'd0, 5'd5, 0, 0, LU_RUN);
    step("lu_cyc2",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, LU_LU);
    step("lu_done",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);

    // Register 0 never hazards.
    step("x0_nohit",  0, 1, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);
    // Matching rd without a load is not a hazard.
    step("noload",    0, 0, 5'd7, 5'd7, 5'd7, 0, 0, Z_RUN);

    // Branch and load-use together: branch wins, no stall.
    step("br_lu",     0, 1, 5'd4, 5'd4, 5'd0, 1, 0, FL_RUN);
    step("fl_cyc2",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FL_FL);
    step("fl_done",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);

    // Memory wait interrupting LU with counter 1.
    step("lu2_hit",   0, 1, 5'd9, 5'd9, 5'd0, 0, 0, LU_RUN);
    step("mw_in_lu",  0, 0, 5'd0, 5'd0, 5'd0, 0, 1, MW_LU);
    step("mw_2",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, MW_MW);
    step("mw_3",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, MW_MW);
    step("mw_leave",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_MW);
    step("lu_resume", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, LU_LU);
    step("lu2_done",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);

    // Branch abandons LU and starts a fresh flush sequence.
    step("lu3_hit",   0, 1, 5'd2, 5'd0, 5'd2, 0, 0, LU_RUN);
    step("br_in_lu",  0, 0, 5'd0, 5'd0, 5'd0, 1, 0, FL_LU);
    step("fl2_cyc2",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FL_FL);
    step("fl2_done",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);

    // Memory wait from RUN beats a simultaneous branch.
    step("mw_br_run", 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, MW_RUN);
    step("mw_back",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_MW);
    step("run_again", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);

    // Reset in the middle of FL aborts it; first cycle after is RUN.
    step("br3",       0, 0, 5'd0, 5'd0, 5'd0, 1, 0, FL_RUN);
    step("rst_in_fl", 1, 0, 5'd0, 5'd0, 5'd0, 1, 1, Z_RUN);
    step("post_rst",  0, 1, 5'd6, 5'd6, 5'd0, 0, 0, LU_RUN);
    step("post_lu",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, LU_LU);
    step("rst_in_lu", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);
    step("end_idle",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, Z_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
